// File: rtl/pwm_deadtime_driver.sv
// rtl/pwm_deadtime_driver.sv - complementary high/low gate-drive pair with programmable dead time
module pwm_deadtime_driver #(
    parameter int DT_WIDTH    = 8,
    parameter int MIN_DEAD    = 1,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 ClkOsc,
    input  logic                 Rst,
    input  logic                 Enable,
    input  logic                 PwmIn,
    input  logic [DT_WIDTH-1:0]  DeadTime,
    output logic                 OutHigh,
    output logic                 OutLow,
    output logic                 Active,
    output logic [CNT_WIDTH-1:0] PulseCount,
    output logic [CNT_WIDTH-1:0] GlitchCount
);
    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_DEAD_H = 3'd1,
        S_HIGH   = 3'd2,
        S_DEAD_L = 3'd3,
        S_LOW    = 3'd4
    } state_t;

    localparam logic [DT_WIDTH-1:0] MIN_DEAD_V = DT_WIDTH'(MIN_DEAD);

    state_t                 state;
    state_t                 state_n;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pwm_s;
    logic [DT_WIDTH-1:0]    dead_cnt;
    logic [DT_WIDTH-1:0]    deff_m1;
    logic [DT_WIDTH-1:0]    deff_req;
    logic                   expired;
    logic                   enter_dead;
    logic                   glitch;

    assign pwm_s    = sync_q[SYNC_STAGES-1];
    assign deff_req = (DeadTime < MIN_DEAD_V) ? MIN_DEAD_V : DeadTime;
    assign expired  = (dead_cnt == deff_m1);
    assign Active   = (state == S_HIGH) || (state == S_LOW);

    always_ff @(posedge ClkOsc or posedge Rst) begin
        if (Rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], PwmIn};
        end
    end

    // A reversal inside a dead window wins over expiry on the same edge.
    always_comb begin
        state_n    = state;
        enter_dead = 1'b0;
        glitch     = 1'b0;
        if (!Enable) begin
            state_n = S_OFF;
        end else begin
            case (state)
                S_OFF: begin
                    state_n    = pwm_s ? S_DEAD_H : S_DEAD_L;
                    enter_dead = 1'b1;
                end
                S_DEAD_H: begin
                    if (!pwm_s) begin
                        state_n    = S_DEAD_L;
                        enter_dead = 1'b1;
                        glitch     = 1'b1;
                    end else if (expired) begin
                        state_n = S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (!pwm_s) begin
                        state_n    = S_DEAD_L;
                        enter_dead = 1'b1;
                    end
                end
                S_DEAD_L: begin
                    if (pwm_s) begin
                        state_n    = S_DEAD_H;
                        enter_dead = 1'b1;
                        glitch     = 1'b1;
                    end else if (expired) begin
                        state_n = S_LOW;
                    end
                end
                S_LOW: begin
                    if (pwm_s) begin
                        state_n    = S_DEAD_H;
                        enter_dead = 1'b1;
                    end
                end
                default: state_n = S_OFF;
            endcase
        end
    end

    // Outputs decode the next state so they move on the same edge as the state.
    always_ff @(posedge ClkOsc or posedge Rst) begin
        if (Rst) begin
            state       <= S_OFF;
            OutHigh     <= 1'b0;
            OutLow      <= 1'b0;
            dead_cnt    <= '0;
            deff_m1     <= '0;
            PulseCount  <= '0;
            GlitchCount <= '0;
        end else begin
            state   <= state_n;
            OutHigh <= (state_n == S_HIGH);
            OutLow  <= (state_n == S_LOW);
            if (enter_dead) begin
                dead_cnt <= '0;
                deff_m1  <= deff_req - DT_WIDTH'(1);
            end else if ((state_n == state) && ((state == S_DEAD_H) || (state == S_DEAD_L))) begin
                dead_cnt <= dead_cnt + DT_WIDTH'(1);
            end
            if ((state_n == S_HIGH) && (state != S_HIGH)) begin
                PulseCount <= PulseCount + CNT_WIDTH'(1);
            end
            if (glitch && (GlitchCount != '1)) begin
                GlitchCount <= GlitchCount + CNT_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_pwm_deadtime_driver.sv
// tb/tb_pwm_deadtime_driver.sv - scoreboard bench for pwm_deadtime_driver
module tb_pwm_deadtime_driver;
    logic       ClkOsc;
    logic       Rst;
    logic       Enable;
    logic       PwmIn;
    logic [7:0] DeadTime;
    logic       OutHigh;
    logic       OutLow;
    logic       Active;
    logic [3:0] PulseCount;
    logic [3:0] GlitchCount;

    typedef struct packed {
        int         edge_n;
        logic [1:0] exp;
    } sb_item_t;

    sb_item_t sb[$];
    int tests;
    int fails;
    int overlap_cnt;

    pwm_deadtime_driver #(
        .DT_WIDTH(8),
        .MIN_DEAD(1),
        .SYNC_STAGES(2),
        .CNT_WIDTH(4)
    ) dut (
        .ClkOsc(ClkOsc),
        .Rst(Rst),
        .Enable(Enable),
        .PwmIn(PwmIn),
        .DeadTime(DeadTime),
        .OutHigh(OutHigh),
        .OutLow(OutLow),
        .Active(Active),
        .PulseCount(PulseCount),
        .GlitchCount(GlitchCount)
    );

    initial ClkOsc = 1'b0;
    always #5 ClkOsc = ~ClkOsc;

    always @(negedge ClkOsc) begin
        if (OutHigh === 1'b1 && OutLow === 1'b1) overlap_cnt = overlap_cnt + 1;
    end

    task automatic do_reset();
        Rst = 1'b1;
        @(negedge ClkOsc);
        Rst = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        Enable = 1'b0;
        PwmIn = 1'b0;
        DeadTime = 8'd0;
        repeat (2) @(negedge ClkOsc);
        tests++; if (OutHigh !== 1'b0) begin fails++; $display("FAIL reset_high got %b expected 0", OutHigh); end
        tests++; if (OutLow !== 1'b0) begin fails++; $display("FAIL reset_low got %b expected 0", OutLow); end
        tests++; if (Active !== 1'b0) begin fails++; $display("FAIL reset_active got %b expected 0", Active); end
        tests++; if (PulseCount !== 4'd0) begin fails++; $display("FAIL reset_pulse got %0d expected 0", PulseCount); end
        tests++; if (GlitchCount !== 4'd0) begin fails++; $display("FAIL reset_glitch got %0d expected 0", GlitchCount); end
        Rst = 1'b0;
    endtask

    task automatic test_turn_on();
        sb_item_t it;
        do_reset();
        DeadTime = 8'd5;
        PwmIn = 1'b0;
        Enable = 1'b1;
        repeat (12) @(negedge ClkOsc);
        tests++; if (OutLow !== 1'b1) begin fails++; $display("FAIL turn_on_settled got %b expected 1", OutLow); end
        sb.delete();
        PwmIn = 1'b1;
        for (int e = 0; e < 9; e++)
            sb.push_back('{edge_n: e, exp: (e < 2) ? 2'b01 : (e < 7) ? 2'b00 : 2'b10});
        for (int e = 0; e < 9; e++) begin
            @(posedge ClkOsc);
            @(negedge ClkOsc);
            while (sb.size() > 0 && sb[0].edge_n == e) begin
                it = sb.pop_front();
                tests++;
                if ({OutHigh, OutLow} !== it.exp) begin
                    fails++;
                    $display("FAIL turn_on edge %0d got %b expected %b", e, {OutHigh, OutLow}, it.exp);
                end
            end
        end
        tests++; if (PulseCount !== 4'd1) begin fails++; $display("FAIL turn_on_pulse got %0d expected 1", PulseCount); end
        tests++; if (Active !== 1'b1) begin fails++; $display("FAIL turn_on_active got %b expected 1", Active); end
    endtask

    task automatic test_min_dead();
        sb_item_t   it;
        logic       going_high;
        logic [1:0] prev;
        logic [1:0] nxt;
        int         r;
        do_reset();
        DeadTime = 8'd0;
        PwmIn = 1'b0;
        Enable = 1'b1;
        repeat (6) @(negedge ClkOsc);
        sb.delete();
        for (int e = 0; e < 60; e++) begin
            going_high = ((e / 10) % 2 == 0);
            PwmIn = going_high;
            prev = going_high ? 2'b01 : 2'b10;
            nxt  = going_high ? 2'b10 : 2'b01;
            r = e % 10;
            sb.push_back('{edge_n: e, exp: (r < 2) ? prev : (r == 2) ? 2'b00 : nxt});
            @(posedge ClkOsc);
            @(negedge ClkOsc);
            while (sb.size() > 0 && sb[0].edge_n == e) begin
                it = sb.pop_front();
                tests++;
                if ({OutHigh, OutLow} !== it.exp) begin
                    fails++;
                    $display("FAIL min_dead edge %0d got %b expected %b", e, {OutHigh, OutLow}, it.exp);
                end
            end
        end
        tests++; if (PulseCount !== 4'd3) begin fails++; $display("FAIL min_dead_pulse got %0d expected 3", PulseCount); end
        tests++; if (GlitchCount !== 4'd0) begin fails++; $display("FAIL min_dead_glitch got %0d expected 0", GlitchCount); end
        tests++; if (overlap_cnt !== 0) begin fails++; $display("FAIL min_dead_overlap got %0d expected 0", overlap_cnt); end
    endtask

    task automatic test_glitch();
        sb_item_t it;
        do_reset();
        DeadTime = 8'd10;
        PwmIn = 1'b0;
        Enable = 1'b1;
        repeat (16) @(negedge ClkOsc);
        sb.delete();
        for (int e = 0; e < 20; e++)
            sb.push_back('{edge_n: e, exp: (e < 2) ? 2'b01 : (e < 16) ? 2'b00 : 2'b01});
        for (int e = 0; e < 20; e++) begin
            PwmIn = (e < 4);
            @(posedge ClkOsc);
            @(negedge ClkOsc);
            while (sb.size() > 0 && sb[0].edge_n == e) begin
                it = sb.pop_front();
                tests++;
                if ({OutHigh, OutLow} !== it.exp) begin
                    fails++;
                    $display("FAIL glitch edge %0d got %b expected %b", e, {OutHigh, OutLow}, it.exp);
                end
            end
        end
        tests++; if (GlitchCount !== 4'd1) begin fails++; $display("FAIL glitch_count got %0d expected 1", GlitchCount); end
        tests++; if (PulseCount !== 4'd0) begin fails++; $display("FAIL glitch_pulse got %0d expected 0", PulseCount); end
    endtask

    task automatic test_enable();
        sb_item_t it;
        do_reset();
        DeadTime = 8'd3;
        PwmIn = 1'b1;
        Enable = 1'b1;
        repeat (10) @(negedge ClkOsc);
        tests++; if (OutHigh !== 1'b1) begin fails++; $display("FAIL enable_settled got %b expected 1", OutHigh); end
        sb.delete();
        for (int e = 0; e < 10; e++)
            sb.push_back('{edge_n: e, exp: (e < 7) ? 2'b00 : 2'b10});
        for (int e = 0; e < 10; e++) begin
            Enable = (e >= 4);
            @(posedge ClkOsc);
            @(negedge ClkOsc);
            if (e == 0) begin
                tests++;
                if (Active !== 1'b0) begin fails++; $display("FAIL enable_off_active got %b expected 0", Active); end
            end
            while (sb.size() > 0 && sb[0].edge_n == e) begin
                it = sb.pop_front();
                tests++;
                if ({OutHigh, OutLow} !== it.exp) begin
                    fails++;
                    $display("FAIL enable edge %0d got %b expected %b", e, {OutHigh, OutLow}, it.exp);
                end
            end
        end
        tests++; if (PulseCount !== 4'd2) begin fails++; $display("FAIL enable_pulse got %0d expected 2", PulseCount); end
    endtask

    task automatic test_async_reset();
        sb_item_t it;
        do_reset();
        DeadTime = 8'd2;
        PwmIn = 1'b1;
        Enable = 1'b1;
        repeat (10) @(negedge ClkOsc);
        tests++; if (OutHigh !== 1'b1) begin fails++; $display("FAIL async_settled got %b expected 1", OutHigh); end
        #2 Rst = 1'b1;
        #1;
        tests++; if (OutHigh !== 1'b0) begin fails++; $display("FAIL async_high got %b expected 0", OutHigh); end
        tests++; if (Active !== 1'b0) begin fails++; $display("FAIL async_active got %b expected 0", Active); end
        tests++; if (PulseCount !== 4'd0) begin fails++; $display("FAIL async_pulse got %0d expected 0", PulseCount); end
        tests++; if (GlitchCount !== 4'd0) begin fails++; $display("FAIL async_glitch got %0d expected 0", GlitchCount); end
        @(negedge ClkOsc);
        Rst = 1'b0;
        // Restart from OFF: the stale-low synchroniser enters DEAD_L, then the
        // reversal lands on the same edge as expiry and must win.
        sb.delete();
        for (int e = 0; e < 6; e++)
            sb.push_back('{edge_n: e, exp: (e < 4) ? 2'b00 : 2'b10});
        for (int e = 0; e < 6; e++) begin
            @(posedge ClkOsc);
            @(negedge ClkOsc);
            while (sb.size() > 0 && sb[0].edge_n == e) begin
                it = sb.pop_front();
                tests++;
                if ({OutHigh, OutLow} !== it.exp) begin
                    fails++;
                    $display("FAIL restart edge %0d got %b expected %b", e, {OutHigh, OutLow}, it.exp);
                end
            end
        end
        tests++; if (GlitchCount !== 4'd1) begin fails++; $display("FAIL restart_glitch got %0d expected 1", GlitchCount); end
    endtask

    task automatic test_counters();
        do_reset();
        DeadTime = 8'd1;
        PwmIn = 1'b0;
        Enable = 1'b1;
        repeat (6) @(negedge ClkOsc);
        for (int p = 0; p < 17; p++) begin
            PwmIn = 1'b1;
            repeat (4) @(negedge ClkOsc);
            PwmIn = 1'b0;
            repeat (4) @(negedge ClkOsc);
        end
        repeat (4) @(negedge ClkOsc);
        tests++; if (PulseCount !== 4'd1) begin fails++; $display("FAIL pulse_wrap got %0d expected 1", PulseCount); end
        tests++; if (GlitchCount !== 4'd0) begin fails++; $display("FAIL pulse_no_glitch got %0d expected 0", GlitchCount); end
        DeadTime = 8'd10;
        for (int i = 0; i < 15; i++) begin
            PwmIn = (i % 2 == 0);
            repeat (2) @(negedge ClkOsc);
        end
        repeat (4) @(negedge ClkOsc);
        tests++; if (GlitchCount !== 4'd14) begin fails++; $display("FAIL glitch_pre_sat got %0d expected 14", GlitchCount); end
        for (int i = 15; i < 25; i++) begin
            PwmIn = (i % 2 == 0);
            repeat (2) @(negedge ClkOsc);
        end
        repeat (4) @(negedge ClkOsc);
        tests++; if (GlitchCount !== 4'd15) begin fails++; $display("FAIL glitch_sat got %0d expected 15", GlitchCount); end
        tests++; if (OutHigh !== 1'b0) begin fails++; $display("FAIL glitch_sat_high got %b expected 0", OutHigh); end
        tests++; if (overlap_cnt !== 0) begin fails++; $display("FAIL overlap_total got %0d expected 0", overlap_cnt); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        overlap_cnt = 0;
        Rst = 1'b1;
        Enable = 1'b0;
        PwmIn = 1'b0;
        DeadTime = 8'd0;
        @(negedge ClkOsc);
        test_reset();
        test_turn_on();
        test_min_dead();
        test_glitch();
        test_enable();
        test_async_reset();
        test_counters();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pwm_deadtime_driver.md
Name: pwm_deadtime_driver

Overview:
Downstream stage of the PWM modulator. It consumes the single-ended PWM output and produces a complementary high-side/low-side gate-drive pair with a programmable dead time between them. The PWM input is resynchronised into the system clock domain. Two status counters support bring-up.

Parameters:
DT_WIDTH, 8, width of the DeadTime input in clock cycles
MIN_DEAD, 1, minimum dead interval in cycles; applied when DeadTime < MIN_DEAD (must be >= 1)
SYNC_STAGES, 2, flip-flop stages in the PwmIn synchroniser (>= 2)
CNT_WIDTH, 16, width of PulseCount and GlitchCount

Ports:
ClkOsc  input  1  system clock; the only clock
Rst  input  1  reset; asynchronous, active-high
Enable  input  1  1 = drive outputs; 0 = both outputs forced off
PwmIn  input  1  PWM from the modulator; treated as asynchronous
DeadTime  input  DT_WIDTH  requested dead interval in ClkOsc cycles
OutHigh  output  1  high-side drive, registered
OutLow  output  1  low-side drive, registered
Active  output  1  1 while in state HIGH or LOW
PulseCount  output  CNT_WIDTH  number of entries into HIGH; wraps
GlitchCount  output  CNT_WIDTH  number of aborted dead intervals; saturates at all-ones

Behaviour:
- Clock and reset: one clock, ClkOsc. Reset Rst is asynchronous and active-high.
- Reset values: state OFF; OutHigh=0, OutLow=0, Active=0; PulseCount=0, GlitchCount=0; synchroniser flops=0; dead counter=0.
- Synchroniser: PwmIn passes through SYNC_STAGES flops. pwm_s is the last stage. A PwmIn level captured at edge e appears on pwm_s after edge e+SYNC_STAGES-1.
- Effective dead time: Deff = max(DeadTime, MIN_DEAD). It is latched on every entry to DEAD_H or DEAD_L. Changes to DeadTime during a dead interval have no effect until the next entry.
- States and output drive:
  - OFF: OutHigh=0, OutLow=0.
  - DEAD_H: OutHigh=0, OutLow=0; waiting to turn the high side on.
  - HIGH: OutHigh=1, OutLow=0.
  - DEAD_L: OutHigh=0, OutLow=0; waiting to turn the low side on.
  - LOW: OutHigh=0, OutLow=1.
  - Outputs are registered decodes of the next state, so they change on the same edge that the state changes.
- Transitions (Enable=1):
  - OFF -> DEAD_H if pwm_s=1, else OFF -> DEAD_L. Enabling always starts with a full dead interval.
  - DEAD_H: counter runs from 0. After Deff cycles in DEAD_H, go to HIGH. If pwm_s=0 before expiry, go to DEAD_L, restart the counter, and increment GlitchCount.
  - DEAD_L: mirror of DEAD_H. After Deff cycles, go to LOW. If pwm_s=1 before expiry, go to DEAD_H and increment GlitchCount.
  - HIGH -> DEAD_L when pwm_s=0. LOW -> DEAD_H when pwm_s=1.
- Enable=0, sampled at any edge: next state is OFF and both outputs are 0 after that edge. The counters hold their values.
- Simultaneous events: Enable=0 has priority over every transition. Dead-counter expiry and a pwm_s reversal on the same edge are resolved as a reversal: the block re-enters the opposite dead state and counts a glitch.
- Timing, with pwm_s changing after edge k:
  - The active output drops after edge k+1.
  - The opposite output rises after edge k+1+Deff.
  - Both outputs are low for exactly Deff cycles.
- Invariants:
  - OutHigh and OutLow are never both 1, including across reset and Enable toggles.
  - Between any deassertion of one output and assertion of the other, both outputs are 0 for at least Deff cycles.
- Counter arithmetic:
  - PulseCount increments on every edge that enters HIGH and wraps all-ones -> 0.
  - GlitchCount stops at all-ones.
- Reset mid-operation: outputs go to 0 immediately, asynchronously, not waiting for a clock edge. After Rst is released the block starts from OFF.

Test Plan:
1. SYNC_STAGES=2, DeadTime=5, Enable=1, PwmIn=0 settled in LOW; PwmIn rises before edge 0 -> OutLow=0 after edge 2; OutHigh=1 after edge 7; PulseCount=1.
2. DeadTime=0, MIN_DEAD=1, 50% square wave with period 20 -> exactly one cycle with both outputs low at each transition; never overlap.
3. DeadTime=10, PwmIn high pulse of 4 cycles from LOW -> OutHigh stays 0; GlitchCount=1; block returns to LOW after 10 low-low cycles following the second reversal.
4. In HIGH, deassert Enable -> both outputs 0 after the next edge; reassert with PwmIn=1 -> DEAD_H for Deff cycles, then OutHigh=1.
5. Assert Rst asynchronously mid-HIGH -> OutHigh=0 before the next clock edge; PulseCount=0, GlitchCount=0.
6. CNT_WIDTH=4, 17 full PWM periods -> PulseCount=1 (wrapped). Force 20 glitches -> GlitchCount=15 (saturated).
